digit_scan_driver: RTL and testbench
====================================

Name: digit_scan_driver

Overview:
- Downstream consumer of the 8-bit result word produced by the top-level arithmetic stage (the `uo_out` sum).
- Accepts one unsigned byte per valid/ready handshake.
- Converts it to three BCD digits with a sequential double-dabble (shift-add-3) engine.
- Drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking.

Parameters:
- SCAN_DIV, 1024, clocks each digit stays selected; legal range ≥1.
- BLANK_LEADING, 1, 1 = blank leading zeros in the hundreds and tens positions.
- SEG_ACTIVE_LOW, 0, 1 = invert `seg` polarity (common-anode display); `dig_sel` is unaffected.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  8  unsigned value to display (0..255).
- busy  output  1  conversion in progress (CONVERT or DONE).
- seg  output  7  segments {g,f,e,d,c,b,a}, active high unless SEG_ACTIVE_LOW.
- dig_sel  output  3  one-hot digit enable: bit0 units, bit1 tens, bit2 hundreds.
- bcd_out  output  12  currently displayed value as {hundreds, tens, units} BCD.

Behaviour:
- Reset (async assert, released synchronously by the environment) clears:
  - state to IDLE, shift/BCD registers to 0, display register to 0;
  - prescaler to 0, digit index to 0.
- Outputs during and after reset:
  - `in_ready`=1, `busy`=0, `bcd_out`=12'h000;
  - `dig_sel`=3'b001, `seg`=7'h3F (units "0"; inverted if SEG_ACTIVE_LOW).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid & in_ready` at edge N: capture `in_data` into the binary shift register, clear the BCD accumulator and the 3-bit iteration counter, go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Counter increments. At the edge where counter==7 (the 8th shift, edge N+8) go to DONE.
  - DONE: at edge N+9, load the display register from the BCD accumulator and return to IDLE.
- Timing: `bcd_out` updates at edge N+9; `in_ready` is high again in the cycle after N+9. Maximum throughput is one word per 10 cycles.
- `in_valid` while not in IDLE is ignored. `in_data` is sampled only on the handshake edge. No buffering.
- Display register holds its value until the next completed conversion.
- Scan prescaler: counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - SCAN_DIV=1: index advances every cycle.
  - Counter width is max(1, clog2(SCAN_DIV)).
- A display update never resets the scan; the new value appears on the currently selected digit immediately.
- `seg` and `dig_sel` are registered: they reflect the digit index and display register of the previous cycle, i.e. a one-cycle lag.
- Decoding:
  - Digit codes 0..9 are standard patterns: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - BCD values >9 cannot occur; the decoder outputs 7'h00 for them.
- Blanking (BLANK_LEADING=1):
  - Hundreds are blank if H==0.
  - Tens are blank if H==0 and T==0.
  - Units are never blank.
  - Blank means `seg`=7'h00 (7'h7F if active-low); `dig_sel` still asserts.
- Reset during CONVERT/DONE aborts immediately: state IDLE, display register cleared to 0.

Decomposition:
- Package `digit_ota_pkg`:
  - state enum {IDLE, CONVERT, DONE};
  - NUM_DIGITS=3;
  - SEG_BLANK and the SEG_0..SEG_9 constants.
- One combinational sub-module, `bcd_to_7seg` (4-bit digit + blank → 7-bit seg). It is instantiated once after the digit mux.
- FSM, double-dabble datapath and scan logic stay in the top.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles, release → `in_ready`=1, `busy`=0, `dig_sel`=001, `seg`=7'h3F, `bcd_out`=000.
- Handshake `in_data`=255 at edge N, with SCAN_DIV=4:
  - `busy`=1 for edges N+1..N+9;
  - `bcd_out`=12'h255 after N+9;
  - scan shows 001/6D, 010/6D, 100/5B, each held for 4 cycles.
- `in_data`=7 → `bcd_out`=007; hundreds and tens `seg`=00, units `seg`=07. With BLANK_LEADING=0, hundreds and tens show 3F.
- `in_data`=105 → tens digit shows 3F (not blanked), hundreds 06, units 6D.
- Back-to-back: `in_valid` held high with 200, then 33 driven during CONVERT → only 200 accepted; 33 accepted at the first IDLE cycle. Final `bcd_out`=033, displayed as blank/4F/4F.
- Mid-conversion reset: accept 99, assert `rst` asynchronously at CONVERT iteration 4 → `in_ready`=1 and `bcd_out`=000 without a clock edge. After release, `seg`=3F on units.

Source files
------------

// File: rtl/digit_ota_pkg.sv
// Shared types and constants for the digit scan driver: FSM states,
// digit count and 7-segment patterns in {g,f,e,d,c,b,a} order.
package digit_ota_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment pattern with blanking.
module bcd_to_7seg
  import digit_ota_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Byte to 3-digit BCD via sequential double-dabble, shown on a multiplexed
// 7-segment display with optional leading-zero blanking.
module digit_scan_driver
  import digit_ota_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel,
  output logic [11:0] bcd_out
);

  localparam int SCAN_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_CNT_W-1:0] SCAN_LAST = SCAN_CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t      state_reg, state_next;
  logic [7:0]  bin_reg, bin_next;
  logic [11:0] bcd_reg, bcd_next;
  logic [2:0]  iter_reg, iter_next;
  logic [11:0] disp_reg, disp_next;
  logic [11:0] bcd_adj;
  logic [19:0] shift_word;

  // Add-3 correction on every nibble before the shift keeps each one a legal BCD digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shift_word = {bcd_adj, bin_reg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      iter_reg  <= '0;
      disp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      iter_reg  <= iter_next;
      disp_reg  <= disp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    iter_next  = iter_reg;
    disp_next  = disp_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          bin_next   = in_data;
          bcd_next   = '0;
          iter_next  = '0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        bcd_next  = shift_word[19:8];
        bin_next  = shift_word[7:0];
        iter_next = iter_reg + 3'd1;
        if (iter_reg == 3'd7) state_next = DONE;
      end
      DONE: begin
        disp_next  = bcd_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CONVERT) || (state_reg == DONE);
  assign bcd_out  = disp_reg;

  logic [SCAN_CNT_W-1:0] scan_cnt_reg;
  logic [1:0]            digit_idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= (digit_idx_reg == LAST_DIGIT) ? 2'd0 : digit_idx_reg + 2'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [2:0] cur_sel;
  logic [6:0] seg_raw;
  logic [6:0] seg_reg;
  logic [2:0] dig_sel_reg;

  always_comb begin
    cur_digit = disp_reg[3:0];
    cur_blank = 1'b0;
    cur_sel   = 3'b001;
    case (digit_idx_reg)
      2'd1: begin
        cur_digit = disp_reg[7:4];
        cur_blank = BLANK_LEADING && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
        cur_sel   = 3'b010;
      end
      2'd2: begin
        cur_digit = disp_reg[11:8];
        cur_blank = BLANK_LEADING && (disp_reg[11:8] == 4'd0);
        cur_sel   = 3'b100;
      end
      default: ;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_raw)
  );

  // Registered outputs keep the display pins glitch-free across digit switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg     <= SEG_0 ^ SEG_POL;
      dig_sel_reg <= 3'b001;
    end else begin
      seg_reg     <= seg_raw ^ SEG_POL;
      dig_sel_reg <= cur_sel;
    end
  end

  assign seg     = seg_reg;
  assign dig_sel = dig_sel_reg;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Randomized scoreboard bench: two driver instances (blanking/active-high and
// no-blanking/active-low) checked against an arithmetic reference model.
module tb_digit_scan_driver;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        in_ready_a, busy_a, in_ready_b, busy_b;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  dig_sel_a, dig_sel_b;
  logic [11:0] bcd_a, bcd_b;

  digit_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .busy(busy_a), .seg(seg_a), .dig_sel(dig_sel_a), .bcd_out(bcd_a)
  );

  digit_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .busy(busy_b), .seg(seg_b), .dig_sel(dig_sel_b), .bcd_out(bcd_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int pos, input bit bl, input bit al);
    int h, t, u, d;
    bit blank;
    logic [6:0] s;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    d = (pos == 0) ? u : (pos == 1) ? t : h;
    blank = bl && ((pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0));
    s = blank ? 7'h00 : 7'(seg_tab[d]);
    return al ? ~s : s;
  endfunction

  function automatic int sel_pos(input logic [2:0] s);
    case (s)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  // Monitor: conversion completions, display content and scan cadence.
  int disp_val = 0;
  int disp_age = 1;
  bit prev_busy = 0;
  int busy_cnt = 0;
  logic [2:0] prev_sel = 3'b001;
  int run_len = 0;
  bit run_valid = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 0;
      busy_cnt  = 0;
      disp_val  = 0;
      disp_age  = 1;
      prev_sel  = 3'b001;
      run_len   = 0;
      run_valid = 0;
    end else begin
      if (busy_a) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(bcd_a), 32'hFFFF);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("bcd_out_a", 32'(bcd_a), 32'(to_bcd(e)));
          check("bcd_out_b", 32'(bcd_b), 32'(to_bcd(e)));
          check("busy_len", 32'(busy_cnt), 32'd9);
          $display("completed value %0d bcd_out=%03h", e, bcd_a);
          disp_val = e;
          disp_age = 0;
        end
        busy_cnt = 0;
      end
      prev_busy = busy_a;

      if (disp_age >= 1) begin
        int pa, pb;
        pa = sel_pos(dig_sel_a);
        pb = sel_pos(dig_sel_b);
        if (pa < 0) check("dig_sel_a_onehot", 32'(dig_sel_a), 32'd1);
        else check("seg_a", 32'(seg_a), 32'(exp_seg(disp_val, pa, 1'b1, 1'b0)));
        if (pb < 0) check("dig_sel_b_onehot", 32'(dig_sel_b), 32'd1);
        else check("seg_b", 32'(seg_b), 32'(exp_seg(disp_val, pb, 1'b0, 1'b1)));
      end
      disp_age++;

      if (dig_sel_a != prev_sel) begin
        if (run_valid) check("scan_hold", 32'(run_len), 32'(SCAN_DIV));
        check("scan_order", 32'(dig_sel_a), 32'({prev_sel[1:0], prev_sel[2]}));
        run_valid = 1;
        run_len   = 1;
        prev_sel  = dig_sel_a;
      end else begin
        run_len++;
      end
    end
  end

  int last_accept = 0;

  // Call aligned to a negedge; returns 1 time unit after the handshake edge.
  task automatic send(input int v, input bit hold);
    int t;
    in_valid = 1'b1;
    in_data  = 8'(v);
    t = 0;
    while (!in_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("handshake_timeout", 32'(t), 32'd0);
    end else begin
      exp_q.push_back(v);
      last_accept = cyc;
      $display("accepted value %0d at cycle %0d", v, cyc);
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_bcd_out"}, 32'(bcd_a), 32'h000);
    check({tag, "_dig_sel"}, 32'(dig_sel_a), 32'b001);
    check({tag, "_seg_a"}, 32'(seg_a), 32'h3F);
    check({tag, "_seg_b"}, 32'(seg_b), 32'h40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int a1, a2;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_release");

    send(255, 0);
    wait_idle();
    repeat (16) @(negedge clk);

    send(7, 0);
    wait_idle();
    repeat (16) @(negedge clk);

    send(105, 0);
    wait_idle();
    repeat (16) @(negedge clk);

    // Valid held high: 33 presented during conversion must wait for IDLE.
    send(200, 1);
    a1 = last_accept;
    in_data = 8'd33;
    send(33, 0);
    a2 = last_accept;
    check("back_to_back_gap", 32'(a2 - a1), 32'd10);
    wait_idle();
    repeat (16) @(negedge clk);

    // Asynchronous reset during CONVERT.
    send(99, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_in_ready_a", 32'(in_ready_a), 32'd1);
    check("abort_in_ready_b", 32'(in_ready_b), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_bcd_out_a", 32'(bcd_a), 32'h000);
    check("abort_bcd_out_b", 32'(bcd_b), 32'h000);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_abort_seg", 32'(seg_a), 32'h3F);
    check("post_abort_dig_sel", 32'(dig_sel_a), 32'b001);

    for (int i = 0; i < 25; i++) begin
      int gap;
      gap = $urandom_range(0, 15);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      send($urandom_range(0, 255), 0);
    end
    wait_idle();
    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
